// File: rtl/alu_result_signature.sv
// Compacts ALU result/zero samples into a 32-bit Galois MISR and compares it against GOLDEN after
// NUM_SAMPLES captures. Optional idle-timeout abort is enabled with `define ALU_SIG_TIMEOUT_EN.
module alu_result_signature #(
   parameter int          NUM_SAMPLES = 9,
   parameter logic [31:0] SEED        = 32'h0000_0000,
   parameter logic [31:0] POLY        = 32'h04C1_1DB7,
   parameter logic [31:0] GOLDEN      = 32'h0000_0000,
   parameter int          TIMEOUT     = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sample_valid,
   input  logic [31:0] ALUResult,
   input  logic        zero,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] signature,
   output logic [15:0] sample_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [15:0] LAST_COUNT = 16'(NUM_SAMPLES - 1);

   state_t      state, state_next;
   logic [31:0] sig_q, sig_next;
   logic [15:0] count_q, count_next;
   logic        timeout_q, timeout_next;

   // One Galois MISR step; the zero flag is folded into bit 0 alongside the result.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] data,
                                             input logic        z);
      logic [31:0] fb;
      fb = sig[31] ? POLY : 32'h0;
      return {sig[30:0], 1'b0} ^ fb ^ {data[31:1], data[0] ^ z};
   endfunction

`ifdef ALU_SIG_TIMEOUT_EN
   localparam int          IDLE_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   logic [IDLE_W-1:0] idle_q, idle_next;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT);
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_next   = state;
      sig_next     = sig_q;
      count_next   = count_q;
      timeout_next = timeout_q;
`ifdef ALU_SIG_TIMEOUT_EN
      idle_next    = idle_q;
`endif

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next   = CAPTURE;
               sig_next     = SEED;
               count_next   = 16'd0;
               timeout_next = 1'b0;
`ifdef ALU_SIG_TIMEOUT_EN
               idle_next    = '0;
`endif
            end
         end

         CAPTURE: begin
            if (sample_valid) begin
               sig_next   = misr_step(sig_q, ALUResult, zero);
               count_next = count_q + 16'd1;
`ifdef ALU_SIG_TIMEOUT_EN
               idle_next  = '0;
`endif
               if (count_q == LAST_COUNT) begin
                  state_next = DONE;
               end
            end
`ifdef ALU_SIG_TIMEOUT_EN
            else if (idle_q == IDLE_LAST) begin
               state_next   = DONE;
               timeout_next = 1'b1;
            end else begin
               idle_next = idle_q + 1'b1;
            end
`endif
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sig_q     <= SEED;
         count_q   <= 16'd0;
         timeout_q <= 1'b0;
`ifdef ALU_SIG_TIMEOUT_EN
         idle_q    <= '0;
`endif
      end else begin
         state     <= state_next;
         sig_q     <= sig_next;
         count_q   <= count_next;
         timeout_q <= timeout_next;
`ifdef ALU_SIG_TIMEOUT_EN
         idle_q    <= idle_next;
`endif
      end
   end

   assign busy         = (state == CAPTURE);
   assign done         = (state == DONE);
   assign pass         = done && (sig_q == GOLDEN) && !timeout_q;
   assign timeout      = done && timeout_q;
   assign signature    = sig_q;
   assign sample_count = count_q;

endmodule
